perf_job_ctrl: RTL and testbench
================================

Name: perf_job_ctrl

Overview:
- Host-side initiator for the nonce-search core `perf_sys`.
- Receives a job as a byte stream over a valid/ready interface: 12 block bytes, then 2 target bytes.
- Drives `block0..block11`, `target` and `start` into `perf_sys`, waits for `finish` under a cycle timeout, then captures `nonce0..nonce3`.
- Returns a 5-byte result frame (status + nonce) over an output valid/ready stream. This replaces the testbench stimulus with synthesizable control.

Parameters:
- TIMEOUT, 65536: cycles spent in WAIT before the job is declared failed; legal range ≥ 2.
- TMR_W, 32: width of the wait timer; must hold TIMEOUT-1.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_byte  in  8  job byte from host.
- in_valid  in  1  in_byte is valid.
- in_ready  out  1  controller accepts in_byte this cycle.
- out_byte  out  8  result byte to host.
- out_valid  out  1  out_byte is valid.
- out_ready  in  1  host accepts out_byte this cycle.
- busy  out  1  high in START, WAIT and SEND.
- block0..block11  out  8 each  job block bytes to perf_sys.
- target  out  16  difficulty target to perf_sys.
- start  out  1  one-cycle job launch pulse.
- finish  in  1  perf_sys done (level or pulse).
- nonce0..nonce3  in  8 each  perf_sys result; valid while finish = 1.

Behaviour:
- Reset: synchronous and active-high. It has priority over all other events and acts from any state, including mid-WAIT and mid-SEND.
- Reset values:
  - state = LOAD, byte index = 0, timer = 0.
  - in_ready = 1, out_valid = 0, out_byte = 0x00, start = 0, busy = 0.
  - block0..11 = 0x00, target = 0x0000.
  - status = 0x00, captured nonce = 0.
- Handshakes:
  - A transfer occurs only on a cycle where valid & ready.
  - The host may drop in_valid at any time; it may hold in_valid with no transfer.
  - out_byte/out_valid stay stable until accepted.
- LOAD:
  - in_ready = 1.
  - Transfer k writes: k = 0..11 → block_k; k = 12 → target[15:8]; k = 13 → target[7:0].
  - On the transfer with k = 13, go to START. in_ready drops the following cycle.
- START: start = 1 for exactly this cycle; timer cleared to 0; next state WAIT.
- Latency: last job byte accepted in cycle N → start high in cycle N+1 → WAIT from cycle N+2.
- WAIT:
  - If finish = 1: capture nonce0..3, set status = 0x00 (FOUND), go to SEND.
  - Else if timer == TIMEOUT-1: set captured nonce = 0, set status = 0x01 (TIMEOUT), go to SEND.
  - Else timer increments.
  - If finish and the timeout occur in the same cycle, finish wins.
- SEND:
  - out_valid = 1. Frame order: status, nonce0, nonce1, nonce2, nonce3.
  - out_valid rises in the cycle after the WAIT exit.
  - After the 5th byte is accepted: go to LOAD; byte index = 0; busy = 0 next cycle.
- Stability: block/target registers change only on LOAD transfers. They are stable from START through SEND and keep their last value until overwritten.
- finish is ignored in LOAD, START and SEND. Only the first finish cycle in WAIT is captured.
- in_valid is ignored (in_ready = 0) in START, WAIT and SEND.
- There is no abort path; reset is the only way out of WAIT before timeout.

Decomposition:
- Shared include `perf_defs.vh` holds:
  - state encodings LOAD = 0, START = 1, WAIT = 2, SEND = 3;
  - JOB_BYTES = 14, RES_BYTES = 5, BLOCK_BYTES = 12;
  - STAT_FOUND = 8'h00, STAT_TIMEOUT = 8'h01.
- One sub-module, `perf_wait_timer`: clear/enable/expire counter parameterized by TIMEOUT and TMR_W.

Test Plan:
- Normal job: send bytes 0x01..0x0C, then 0x12, 0x34. Check:
  - block_k = k+1 and target = 0x1234 when start pulses;
  - start high exactly 1 cycle;
  - perf_sys model asserts finish 10 cycles later with nonce = 0xDE,0xAD,0xBE,0xEF;
  - out stream = 0x00, 0xDE, 0xAD, 0xBE, 0xEF.
- Timeout with TIMEOUT = 8 and finish held low: out stream = 0x01, 0x00, 0x00, 0x00, 0x00 exactly 9 cycles after start; then finish asserted at timer = 7 on a rerun must give status 0x00.
- Backpressure: out_ready toggles 1-0-0-1 and in_valid has random gaps. Check no byte is lost or duplicated, and out_byte is stable while out_valid & !out_ready.
- Ignored inputs: finish = 1 during LOAD causes no state change; in_valid during WAIT gives in_ready = 0 and the job registers unchanged.
- Reset mid-WAIT (cycle 3 of WAIT): next cycle all outputs at reset values. A following full job completes normally.

Source files
------------

// File: rtl/perf_job_ctrl_pkg.sv
// Shared types and constants for the perf_sys job controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package perf_job_ctrl_pkg;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    SEND  = 2'd3
  } state_t;

  localparam int JOB_BYTES   = 14;
  localparam int RES_BYTES   = 5;
  localparam int BLOCK_BYTES = 12;

  localparam logic [7:0] STAT_FOUND   = 8'h00;
  localparam logic [7:0] STAT_TIMEOUT = 8'h01;

  // Byte-index landmarks within the job and result frames.
  localparam logic [3:0] IDX_TGT_HI   = 4'(BLOCK_BYTES);
  localparam logic [3:0] IDX_JOB_LAST = 4'(JOB_BYTES - 1);
  localparam logic [3:0] IDX_RES_LAST = 4'(RES_BYTES - 1);

  // Result frame byte at position idx: status first, then nonce MSB-first.
  function automatic logic [7:0] res_byte(input logic [2:0]  idx,
                                          input logic [7:0]  status,
                                          input logic [31:0] nonce);
    logic [7:0] b;
    case (idx)
      3'd0:    b = status;
      3'd1:    b = nonce[31:24];
      3'd2:    b = nonce[23:16];
      3'd3:    b = nonce[15:8];
      3'd4:    b = nonce[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/perf_wait_timer.sv
// Wait-phase cycle counter with clear, enable and terminal-count flag.
// Latency: expired reflects the registered count combinationally.
// Backpressure: none; the count saturates at TIMEOUT-1 until cleared.
module perf_wait_timer #(
  parameter int TIMEOUT = 65536,
  parameter int TMR_W   = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [TMR_W-1:0] LAST = TMR_W'(TIMEOUT - 1);

  logic [TMR_W-1:0] cnt;

  // Count up while enabled; hold at the terminal value so expired stays asserted.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (en && !expired) begin
      cnt <= cnt + TMR_W'(1);
    end
  end

  assign expired = (cnt == LAST);

endmodule

// File: rtl/perf_job_ctrl.sv
// Host-side job controller: loads a 14-byte job, launches perf_sys, returns a 5-byte result.
// Latency: last job byte in cycle N -> start in N+1 -> WAIT from N+2; result valid the cycle after WAIT exit.
// Backpressure: in_ready only in LOAD; out_byte/out_valid held stable until out_ready.
module perf_job_ctrl
  import perf_job_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 65536,
  parameter int TMR_W   = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  in_byte,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  out_byte,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic [7:0]  block0,
  output logic [7:0]  block1,
  output logic [7:0]  block2,
  output logic [7:0]  block3,
  output logic [7:0]  block4,
  output logic [7:0]  block5,
  output logic [7:0]  block6,
  output logic [7:0]  block7,
  output logic [7:0]  block8,
  output logic [7:0]  block9,
  output logic [7:0]  block10,
  output logic [7:0]  block11,
  output logic [15:0] target,
  output logic        start,
  input  logic        finish,
  input  logic [7:0]  nonce0,
  input  logic [7:0]  nonce1,
  input  logic [7:0]  nonce2,
  input  logic [7:0]  nonce3
);

  state_t      state;
  logic [3:0]  idx;
  logic [7:0]  blk [BLOCK_BYTES];
  logic [7:0]  status;
  logic [31:0] nonce_q;
  logic        tmr_expired;
  logic        in_xfer;
  logic        out_xfer;

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

  perf_wait_timer #(
    .TIMEOUT (TIMEOUT),
    .TMR_W   (TMR_W)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clr     (state == START),
    .en      (state == WAIT),
    .expired (tmr_expired)
  );

  // Job load, launch, wait and result streaming; every output is registered here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= LOAD;
      idx       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_byte  <= 8'h00;
      start     <= 1'b0;
      busy      <= 1'b0;
      target    <= 16'h0000;
      status    <= STAT_FOUND;
      nonce_q   <= '0;
      for (int i = 0; i < BLOCK_BYTES; i++) blk[i] <= 8'h00;
    end else begin
      case (state)
        LOAD: begin
          if (in_xfer) begin
            for (int i = 0; i < BLOCK_BYTES; i++) begin
              if (idx == 4'(i)) blk[i] <= in_byte;
            end
            if (idx == IDX_TGT_HI)   target[15:8] <= in_byte;
            if (idx == IDX_JOB_LAST) target[7:0]  <= in_byte;
            if (idx == IDX_JOB_LAST) begin
              idx      <= '0;
              in_ready <= 1'b0;
              start    <= 1'b1;
              busy     <= 1'b1;
              state    <= START;
            end else begin
              idx <= idx + 4'd1;
            end
          end
        end
        START: begin
          start <= 1'b0;
          state <= WAIT;
        end
        WAIT: begin
          // finish takes precedence over a coincident timeout
          if (finish) begin
            nonce_q   <= {nonce0, nonce1, nonce2, nonce3};
            status    <= STAT_FOUND;
            out_byte  <= STAT_FOUND;
            out_valid <= 1'b1;
            state     <= SEND;
          end else if (tmr_expired) begin
            nonce_q   <= '0;
            status    <= STAT_TIMEOUT;
            out_byte  <= STAT_TIMEOUT;
            out_valid <= 1'b1;
            state     <= SEND;
          end
        end
        SEND: begin
          if (out_xfer) begin
            if (idx == IDX_RES_LAST) begin
              idx       <= '0;
              out_valid <= 1'b0;
              out_byte  <= 8'h00;
              in_ready  <= 1'b1;
              busy      <= 1'b0;
              state     <= LOAD;
            end else begin
              idx      <= idx + 4'd1;
              out_byte <= res_byte(idx[2:0] + 3'd1, status, nonce_q);
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

  assign block0  = blk[0];
  assign block1  = blk[1];
  assign block2  = blk[2];
  assign block3  = blk[3];
  assign block4  = blk[4];
  assign block5  = blk[5];
  assign block6  = blk[6];
  assign block7  = blk[7];
  assign block8  = blk[8];
  assign block9  = blk[9];
  assign block10 = blk[10];
  assign block11 = blk[11];

endmodule

// File: tb/tb_perf_job_ctrl.sv
// Directed + randomized bench for perf_job_ctrl with a behavioural perf_sys/host model.
// Latency: expectations derived from job-level timing rules (start, WAIT length, result frame).
// Backpressure: random in_valid gaps and a 1-0-0-1 out_ready pattern.
module tb_perf_job_ctrl;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  in_byte;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  out_byte;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic [7:0]  block [12];
  logic [15:0] target;
  logic        start;
  logic        finish;
  logic [7:0]  n0, n1, n2, n3;

  int total = 0;
  int bad   = 0;

  logic [7:0] jb      [14];
  logic [7:0] last_jb [14];

  perf_job_ctrl #(.TIMEOUT(TO), .TMR_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_byte   (in_byte),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_byte  (out_byte),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .block0    (block[0]),
    .block1    (block[1]),
    .block2    (block[2]),
    .block3    (block[3]),
    .block4    (block[4]),
    .block5    (block[5]),
    .block6    (block[6]),
    .block7    (block[7]),
    .block8    (block[8]),
    .block9    (block[9]),
    .block10   (block[10]),
    .block11   (block[11]),
    .target    (target),
    .start     (start),
    .finish    (finish),
    .nonce0    (n0),
    .nonce1    (n1),
    .nonce2    (n2),
    .nonce3    (n3)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 1);
    chk({tag, "_out_valid"}, 32'(out_valid), 0);
    chk({tag, "_out_byte"}, 32'(out_byte), 0);
    chk({tag, "_start"}, 32'(start), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_target"}, 32'(target), 0);
    for (int i = 0; i < 12; i++) chk({tag, "_block"}, 32'(block[i]), 0);
  endtask

  task automatic send_job(input logic [7:0] b [14], input bit gaps);
    int k = 0;
    int cyc = 0;
    while (k < 14 && cyc < 500) begin
      if (!gaps || $urandom_range(0, 2) != 0) begin
        in_valid = 1'b1;
        in_byte  = b[k];
        if (in_ready) k++;
      end else begin
        in_valid = 1'b0;
        in_byte  = 8'($urandom);
      end
      step();
      cyc++;
    end
    in_valid = 1'b0;
    chk("load_complete", 32'(k), 14);
  endtask

  // d: cycles after the start cycle at which finish rises (held high), -1 = never.
  // rst_at: cycle after start at which reset is pulsed, -1 = never.
  task automatic run_job(input logic [7:0] b [14], input int d, input logic [31:0] nonce,
                         input bit gaps, input logic [3:0] pat, input int rst_at);
    logic [7:0]  exp_frame [5];
    logic [7:0]  exp_stat;
    logic [31:0] exp_nonce;
    logic [7:0]  hold_byte;
    int          exp_c;
    int          c;
    int          idx;
    int          p;
    int          cyc;
    bit          held;
    bit          r;

    send_job(b, gaps);
    chk("start_high", 32'(start), 1);
    chk("busy_at_start", 32'(busy), 1);
    chk("in_ready_at_start", 32'(in_ready), 0);
    for (int i = 0; i < 12; i++) chk("block_at_start", 32'(block[i]), 32'(b[i]));
    chk("target_at_start", 32'(target), {16'h0, b[12], b[13]});

    // Reference: a finish seen during WAIT (cycles 1..TO after start) wins; else timeout.
    if (d >= 1 && d <= TO) begin
      exp_stat = 8'h00; exp_nonce = nonce; exp_c = d + 1;
    end else begin
      exp_stat = 8'h01; exp_nonce = 32'h0; exp_c = TO + 1;
    end
    exp_frame[0] = exp_stat;
    exp_frame[1] = exp_nonce[31:24];
    exp_frame[2] = exp_nonce[23:16];
    exp_frame[3] = exp_nonce[15:8];
    exp_frame[4] = exp_nonce[7:0];

    c = 0;
    while (!out_valid && c < TO + 20) begin
      finish = (d >= 0 && c >= d);
      if (d >= 0 && c == d) {n0, n1, n2, n3} = nonce;
      else                  {n0, n1, n2, n3} = $urandom;
      in_valid = ($urandom_range(0, 1) == 1);
      in_byte  = 8'($urandom);
      if (c == rst_at) reset = 1'b1;
      step();
      c++;
      if (reset) begin
        reset    = 1'b0;
        finish   = 1'b0;
        in_valid = 1'b0;
        check_reset_vals("reset_mid_wait");
        for (int i = 0; i < 14; i++) last_jb[i] = 8'h00;
        return;
      end
      if (c == 1) chk("start_one_cycle", 32'(start), 0);
      chk("in_ready_busy", 32'(in_ready), 0);
      chk("busy_wait", 32'(busy), 1);
    end
    in_valid = 1'b0;
    chk("result_latency", 32'(c), 32'(exp_c));
    for (int i = 0; i < 12; i++) chk("block_stable", 32'(block[i]), 32'(b[i]));
    chk("target_stable", 32'(target), {16'h0, b[12], b[13]});

    idx = 0; p = 0; cyc = 0; held = 1'b0; hold_byte = 8'h00;
    while (idx < 5 && cyc < 40) begin
      chk("out_valid", 32'(out_valid), 1);
      chk("out_byte", 32'(out_byte), 32'(exp_frame[idx]));
      if (held) chk("out_byte_stable", 32'(out_byte), 32'(hold_byte));
      r = pat[3 - (p % 4)];
      p++;
      out_ready = r;
      if (r) begin
        idx++;
        held = 1'b0;
      end else begin
        held = 1'b1;
        hold_byte = out_byte;
      end
      {n0, n1, n2, n3} = $urandom;
      step();
      cyc++;
    end
    out_ready = 1'b0;
    finish    = 1'b0;
    chk("frame_complete", 32'(idx), 5);
    chk("out_valid_after", 32'(out_valid), 0);
    chk("busy_after", 32'(busy), 0);
    chk("in_ready_after", 32'(in_ready), 1);
    for (int i = 0; i < 14; i++) last_jb[i] = b[i];
  endtask

  task automatic rand_job();
    for (int i = 0; i < 14; i++) jb[i] = 8'($urandom);
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_byte   = 8'h00;
    out_ready = 1'b0;
    finish    = 1'b0;
    {n0, n1, n2, n3} = 32'h0;
    step();
    step();
    check_reset_vals("reset");
    reset = 1'b0;
    step();
    check_reset_vals("idle");

    // Normal job with fixed pattern and nonce DEADBEEF after 10 cycles.
    for (int i = 0; i < 12; i++) jb[i] = 8'(i + 1);
    jb[12] = 8'h12;
    jb[13] = 8'h34;
    run_job(jb, 10, 32'hDEADBEEF, 1'b0, 4'b1111, -1);

    // Timeout: finish never rises.
    rand_job();
    run_job(jb, -1, 32'h0, 1'b1, 4'b1111, -1);

    // Finish coincides with the last timer value: finish wins.
    rand_job();
    run_job(jb, TO, $urandom, 1'b0, 4'b1111, -1);

    // Backpressure with random input gaps.
    for (int j = 0; j < 3; j++) begin
      rand_job();
      run_job(jb, $urandom_range(1, TO - 1), $urandom, 1'b1, 4'b1001, -1);
    end

    // finish in LOAD is ignored; job registers keep the last job.
    finish = 1'b1;
    for (int j = 0; j < 5; j++) begin
      {n0, n1, n2, n3} = $urandom;
      step();
      chk("load_finish_in_ready", 32'(in_ready), 1);
      chk("load_finish_busy", 32'(busy), 0);
      chk("load_finish_out_valid", 32'(out_valid), 0);
      chk("load_finish_start", 32'(start), 0);
    end
    finish = 1'b0;
    for (int i = 0; i < 12; i++) chk("block_retained", 32'(block[i]), 32'(last_jb[i]));
    chk("target_retained", 32'(target), {16'h0, last_jb[12], last_jb[13]});

    // Reset in the third WAIT cycle, then a full job.
    rand_job();
    run_job(jb, 10, $urandom, 1'b0, 4'b1111, 3);
    step();
    rand_job();
    run_job(jb, 5, $urandom, 1'b1, 4'b1001, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
